// File: rtl/writeback_pkg.sv
// Shared constants and types for the writeback stage and its CSR file.
package writeback_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned CODE_W = 4;

  // Machine-mode CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP       = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_AW-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_AW-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_AW-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_AW-1:0] CSR_INSTRETH  = 12'hC82;

  // rd source select
  typedef enum logic [1:0] {
    WSEL_ALU     = 2'b00,
    WSEL_CSR     = 2'b01,
    WSEL_LOAD    = 2'b10,
    WSEL_NEXT_PC = 2'b11
  } wsel_e;

  // Interrupt cause codes (also the mip/mie bit positions)
  localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;
  localparam int unsigned MCAUSE_IRQ_BIT = 31;

  // mstatus fields
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // Implemented mie bits
  localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic {
    WFI_RUN   = 1'b0,
    WFI_SLEEP = 1'b1
  } wfi_state_e;

  // Compose an mcause value from the interrupt flag and a 4-bit code
  function automatic logic [XLEN-1:0] mcause_value(input logic is_irq,
                                                   input logic [CODE_W-1:0] code);
    mcause_value = {is_irq, 27'd0, code};
  endfunction

endpackage

// File: rtl/writeback_csr_file.sv
// Machine-mode CSR storage, read mux, 64-bit counters and trap/mret side effects.
module csr_file
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_csr_we,
  input  logic [CSR_AW-1:0] i_csr_addr,
  input  logic [XLEN-1:0]   i_csr_wdata,
  input  logic              i_retire,
  input  logic              i_trap,
  input  logic [XLEN-1:0]   i_trap_cause,
  input  logic [XLEN-1:0]   i_trap_pc,
  input  logic              i_mret,
  input  logic              i_meip,
  input  logic              i_mtip,
  input  logic              i_msip,
  input  logic [CSR_AW-1:0] i_read_addr,
  output logic [XLEN-1:0]   o_read_data,
  output logic [XLEN-1:0]   o_trap_vector,
  output logic [XLEN-1:0]   o_mepc,
  output logic              o_mstatus_mie,
  output logic [XLEN-1:0]   o_pending
);

  logic              r_mstatus_mie;
  logic              r_mstatus_mpie;
  logic [XLEN-1:0]   r_mie;
  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mscratch;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [CNT_W-1:0]  r_mcycle;
  logic [CNT_W-1:0]  r_minstret;

  logic [XLEN-1:0]   w_mip;
  logic [XLEN-1:0]   w_mstatus;

  // Assemble the sparse mip and mstatus views
  always_comb begin
    w_mip                     = '0;
    w_mip[IRQ_MSI]            = i_msip;
    w_mip[IRQ_MTI]            = i_mtip;
    w_mip[IRQ_MEI]            = i_meip;
    w_mstatus                 = '0;
    w_mstatus[MSTATUS_MIE]    = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE]   = r_mstatus_mpie;
  end

  // CSR read mux; unmapped addresses read zero
  always_comb begin
    o_read_data = '0;
    case (i_read_addr)
      CSR_MSTATUS:                o_read_data = w_mstatus;
      CSR_MIE:                    o_read_data = r_mie;
      CSR_MTVEC:                  o_read_data = r_mtvec;
      CSR_MSCRATCH:               o_read_data = r_mscratch;
      CSR_MEPC:                   o_read_data = r_mepc;
      CSR_MCAUSE:                 o_read_data = r_mcause;
      CSR_MIP:                    o_read_data = w_mip;
      CSR_MCYCLE,   CSR_CYCLE:    o_read_data = r_mcycle[XLEN-1:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   o_read_data = r_mcycle[CNT_W-1:XLEN];
      CSR_MINSTRET, CSR_INSTRET:  o_read_data = r_minstret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: o_read_data = r_minstret[CNT_W-1:XLEN];
      default:                    o_read_data = '0;
    endcase
  end

  // State update: counters tick, a CSR write overrides its counter's tick, trap/mret last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (i_retire) begin
        r_minstret <= r_minstret + 64'd1;
      end
      if (i_csr_we) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= i_csr_wdata[MSTATUS_MIE];
            r_mstatus_mpie <= i_csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:       r_mie      <= i_csr_wdata & MIE_MASK;
          CSR_MTVEC:     r_mtvec    <= i_csr_wdata;
          CSR_MSCRATCH:  r_mscratch <= i_csr_wdata;
          CSR_MEPC:      r_mepc     <= {i_csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE:    r_mcause   <= i_csr_wdata;
          CSR_MCYCLE:    r_mcycle   <= {r_mcycle[CNT_W-1:XLEN], i_csr_wdata};
          CSR_MCYCLEH:   r_mcycle   <= {i_csr_wdata, r_mcycle[XLEN-1:0]};
          CSR_MINSTRET:  r_minstret <= {r_minstret[CNT_W-1:XLEN], i_csr_wdata};
          CSR_MINSTRETH: r_minstret <= {i_csr_wdata, r_minstret[XLEN-1:0]};
          default: ;
        endcase
      end
      if (i_trap) begin
        r_mepc         <= {i_trap_pc[XLEN-1:2], 2'b00};
        r_mcause       <= i_trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

  assign o_trap_vector = {r_mtvec[XLEN-1:2], 2'b00};
  assign o_mepc        = r_mepc;
  assign o_mstatus_mie = r_mstatus_mie;
  assign o_pending     = w_mip & r_mie;

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: retire priority, rd write mux, trap redirect and wfi sleep FSM.
module writeback
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   next_pc_in,
  input  logic [XLEN-1:0]   alu_data_in,
  input  logic [XLEN-1:0]   csr_data_in,
  input  logic [XLEN-1:0]   load_data_in,
  input  logic [1:0]        write_select_in,
  input  logic [REG_AW-1:0] rd_address_in,
  input  logic [CSR_AW-1:0] csr_address_in,
  input  logic              csr_write_in,
  input  logic              mret_in,
  input  logic              wfi_in,
  input  logic              valid_in,
  input  logic              exception_in,
  input  logic [CODE_W-1:0] ecause_in,
  input  logic              meip,
  input  logic              mtip,
  input  logic              msip,
  input  logic [CSR_AW-1:0] csr_read_address,
  output logic [XLEN-1:0]   csr_read_data,
  output logic              rd_write,
  output logic [REG_AW-1:0] rd_address,
  output logic [XLEN-1:0]   rd_data,
  output logic              trap,
  output logic [XLEN-1:0]   trap_address,
  output logic              wfi_stall
);

  wfi_state_e        r_state;
  wfi_state_e        w_state_next;

  logic [XLEN-1:0]   w_pending;
  logic [XLEN-1:0]   w_trap_vector;
  logic [XLEN-1:0]   w_mepc;
  logic [XLEN-1:0]   w_csr_rdata;
  logic              w_mstatus_mie;
  logic              w_irq;
  logic [CODE_W-1:0] w_irq_code;
  logic              w_take_irq;
  logic              w_take_exc;
  logic              w_trap_event;
  logic              w_retire;
  logic              w_do_mret;
  logic [XLEN-1:0]   w_trap_cause;

  // Pick the highest-priority enabled pending interrupt: MEI, MSI, MTI
  always_comb begin
    w_irq      = 1'b0;
    w_irq_code = IRQ_MEI;
    if (w_pending[IRQ_MEI]) begin
      w_irq      = 1'b1;
      w_irq_code = IRQ_MEI;
    end else if (w_pending[IRQ_MSI]) begin
      w_irq      = 1'b1;
      w_irq_code = IRQ_MSI;
    end else if (w_pending[IRQ_MTI]) begin
      w_irq      = 1'b1;
      w_irq_code = IRQ_MTI;
    end
  end

  // Retire priority: interrupt, exception, then mret/normal retire
  always_comb begin
    w_take_irq   = valid_in & w_irq & w_mstatus_mie;
    w_take_exc   = valid_in & ~w_take_irq & exception_in;
    w_trap_event = w_take_irq | w_take_exc;
    w_retire     = valid_in & ~w_trap_event;
    w_do_mret    = w_retire & mret_in;
    w_trap_cause = w_take_irq ? mcause_value(1'b1, w_irq_code)
                              : mcause_value(1'b0, ecause_in);
  end

  // Register-file write data source
  always_comb begin
    rd_data = alu_data_in;
    case (wsel_e'(write_select_in))
      WSEL_ALU:     rd_data = alu_data_in;
      WSEL_CSR:     rd_data = csr_data_in;
      WSEL_LOAD:    rd_data = load_data_in;
      WSEL_NEXT_PC: rd_data = next_pc_in;
      default:      rd_data = alu_data_in;
    endcase
  end

  // Externally visible retire/trap outputs, quiet while reset is held
  always_comb begin
    rd_write      = ~reset & w_retire & (rd_address_in != 5'd0);
    rd_address    = reset ? 5'd0 : rd_address_in;
    trap          = ~reset & (w_trap_event | w_do_mret);
    trap_address  = w_do_mret ? w_mepc : w_trap_vector;
    csr_read_data = reset ? 32'd0 : w_csr_rdata;
    wfi_stall     = ~reset & (r_state == WFI_SLEEP);
  end

  // wfi state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WFI_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // wfi next state: sleep on a retiring wfi, wake on any enabled pending interrupt
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WFI_RUN:   if (w_retire && wfi_in) w_state_next = WFI_SLEEP;
      WFI_SLEEP: if (w_pending != 32'd0) w_state_next = WFI_RUN;
      default:   w_state_next = WFI_RUN;
    endcase
  end

  csr_file u_csr_file (
    .clk           (clk),
    .reset         (reset),
    .i_csr_we      (w_retire & csr_write_in),
    .i_csr_addr    (csr_address_in),
    .i_csr_wdata   (alu_data_in),
    .i_retire      (w_retire),
    .i_trap        (w_trap_event),
    .i_trap_cause  (w_trap_cause),
    .i_trap_pc     (pc_in),
    .i_mret        (w_do_mret),
    .i_meip        (meip),
    .i_mtip        (mtip),
    .i_msip        (msip),
    .i_read_addr   (csr_read_address),
    .o_read_data   (w_csr_rdata),
    .o_trap_vector (w_trap_vector),
    .o_mepc        (w_mepc),
    .o_mstatus_mie (w_mstatus_mie),
    .o_pending     (w_pending)
  );

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for the writeback stage.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
  logic [3:0]  ecause_in;
  logic        meip, mtip, msip;
  logic [11:0] csr_read_address;
  logic [31:0] csr_read_data;
  logic        rd_write;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        trap;
  logic [31:0] trap_address;
  logic        wfi_stall;

  localparam logic [5:0] E_RDW = 6'b000001;
  localparam logic [5:0] E_RDD = 6'b000010;
  localparam logic [5:0] E_TRP = 6'b000100;
  localparam logic [5:0] E_TA  = 6'b001000;
  localparam logic [5:0] E_CSR = 6'b010000;
  localparam logic [5:0] E_STL = 6'b100000;

  typedef struct packed {
    logic [5:0]  en;
    logic        rdw;
    logic [31:0] rdd;
    logic        trp;
    logic [31:0] ta;
    logic [31:0] csr;
    logic        stall;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_checks = 0;
  int    n_errors = 0;

  writeback dut (
    .clk              (clk),
    .reset            (reset),
    .pc_in            (pc_in),
    .next_pc_in       (next_pc_in),
    .alu_data_in      (alu_data_in),
    .csr_data_in      (csr_data_in),
    .load_data_in     (load_data_in),
    .write_select_in  (write_select_in),
    .rd_address_in    (rd_address_in),
    .csr_address_in   (csr_address_in),
    .csr_write_in     (csr_write_in),
    .mret_in          (mret_in),
    .wfi_in           (wfi_in),
    .valid_in         (valid_in),
    .exception_in     (exception_in),
    .ecause_in        (ecause_in),
    .meip             (meip),
    .mtip             (mtip),
    .msip             (msip),
    .csr_read_address (csr_read_address),
    .csr_read_data    (csr_read_data),
    .rd_write         (rd_write),
    .rd_address       (rd_address),
    .rd_data          (rd_data),
    .trap             (trap),
    .trap_address     (trap_address),
    .wfi_stall        (wfi_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pc_in = 32'd0; next_pc_in = 32'd0; alu_data_in = 32'd0; csr_data_in = 32'd0;
    load_data_in = 32'd0; write_select_in = 2'b00; rd_address_in = 5'd0;
    csr_address_in = 12'd0; csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0;
    valid_in = 1'b0; exception_in = 1'b0; ecause_in = 4'd0;
    meip = 1'b0; mtip = 1'b0; msip = 1'b0; csr_read_address = 12'd0;
  endtask

  // Push the expectation for the inputs just driven, compare it when outputs settle
  task automatic cyc(input string tag, input logic [5:0] en, input logic rdw,
                     input logic [31:0] rdd, input logic trp, input logic [31:0] ta,
                     input logic [31:0] csr, input logic stall);
    exp_t  e;
    string t;
    e = '{en: en, rdw: rdw, rdd: rdd, trp: trp, ta: ta, csr: csr, stall: stall};
    sb.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    e = sb.pop_front();
    t = tq.pop_front();
    if (e.en[0]) check({t, ".rd_write"},      32'(rd_write),  32'(e.rdw));
    if (e.en[1]) check({t, ".rd_data"},       rd_data,        e.rdd);
    if (e.en[2]) check({t, ".trap"},          32'(trap),      32'(e.trp));
    if (e.en[3]) check({t, ".trap_address"},  trap_address,   e.ta);
    if (e.en[4]) check({t, ".csr_read_data"}, csr_read_data,  e.csr);
    if (e.en[5]) check({t, ".wfi_stall"},     32'(wfi_stall), 32'(e.stall));
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd_csr(input string tag, input logic [11:0] a, input logic [31:0] v);
    csr_read_address = a;
    cyc(tag, E_CSR | E_TRP, 1'b0, 32'd0, 1'b0, 32'd0, v, 1'b0);
  endtask

  task automatic wr_csr(input string tag, input logic [11:0] a, input logic [31:0] v);
    valid_in = 1'b1; csr_write_in = 1'b1; csr_address_in = a; alu_data_in = v;
    cyc(tag, E_RDW | E_TRP, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Reset with a valid CSR write pending: nothing may commit
    valid_in = 1'b1; csr_write_in = 1'b1; csr_address_in = 12'h340; alu_data_in = 32'hABCD;
    rd_address_in = 5'd5; csr_read_address = 12'h340;
    cyc("reset", E_RDW | E_TRP | E_CSR | E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;

    rd_csr("mcycle0", 12'hB00, 32'd0);
    rd_csr("mcycle1", 12'hB00, 32'd1);
    rd_csr("mscratch_rst", 12'h340, 32'd0);

    // Load retire
    valid_in = 1'b1; write_select_in = 2'b10; rd_address_in = 5'd5;
    load_data_in = 32'hDEADBEEF; csr_read_address = 12'hB02;
    cyc("load", E_RDW | E_RDD | E_TRP | E_CSR, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b0);
    rd_csr("minstret1", 12'hB02, 32'd1);
    rd_csr("instret1", 12'hC02, 32'd1);

    valid_in = 1'b1; write_select_in = 2'b11; next_pc_in = 32'h44; rd_address_in = 5'd0;
    cyc("npc_rd0", E_RDW | E_RDD, 1'b0, 32'h44, 1'b0, 32'd0, 32'd0, 1'b0);
    valid_in = 1'b1; write_select_in = 2'b01; csr_data_in = 32'h55; rd_address_in = 5'd1;
    cyc("sel_csr", E_RDW | E_RDD, 1'b1, 32'h55, 1'b0, 32'd0, 32'd0, 1'b0);
    valid_in = 1'b1; write_select_in = 2'b00; alu_data_in = 32'h77; rd_address_in = 5'd31;
    cyc("sel_alu", E_RDW | E_RDD, 1'b1, 32'h77, 1'b0, 32'd0, 32'd0, 1'b0);
    rd_csr("minstret4", 12'hB02, 32'd4);

    // Exception with mtvec mode bits set; the CSR write on it must be dropped
    wr_csr("wr_mtvec", 12'h305, 32'h80000103);
    rd_csr("mtvec", 12'h305, 32'h80000103);
    valid_in = 1'b1; exception_in = 1'b1; ecause_in = 4'd2; pc_in = 32'h40;
    rd_address_in = 5'd7; write_select_in = 2'b10; load_data_in = 32'd1;
    csr_write_in = 1'b1; csr_address_in = 12'h340; alu_data_in = 32'hBAD;
    cyc("exc", E_RDW | E_TRP | E_TA, 1'b0, 32'd0, 1'b1, 32'h80000100, 32'd0, 1'b0);
    rd_csr("exc_mepc", 12'h341, 32'h40);
    rd_csr("exc_mcause", 12'h342, 32'd2);
    rd_csr("exc_mscratch", 12'h340, 32'd0);
    rd_csr("exc_minstret", 12'hB02, 32'd5);
    exception_in = 1'b1;
    cyc("invalid_exc", E_RDW | E_TRP, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Timer interrupt, then mret
    wr_csr("wr_mie", 12'h304, 32'hFFFFFFFF);
    rd_csr("mie", 12'h304, 32'h888);
    wr_csr("wr_mstatus", 12'h300, 32'h8);
    rd_csr("mstatus_mie", 12'h300, 32'h8);
    valid_in = 1'b1; mtip = 1'b1; pc_in = 32'h100; rd_address_in = 5'd3; alu_data_in = 32'd9;
    cyc("irq_mti", E_RDW | E_TRP | E_TA, 1'b0, 32'd0, 1'b1, 32'h80000100, 32'd0, 1'b0);
    rd_csr("irq_mcause", 12'h342, 32'h80000007);
    rd_csr("irq_mstatus", 12'h300, 32'h80);
    rd_csr("irq_mepc", 12'h341, 32'h100);
    mtip = 1'b1;
    rd_csr("mip", 12'h344, 32'h80);
    valid_in = 1'b1; mret_in = 1'b1; pc_in = 32'h104;
    cyc("mret", E_TRP | E_TA, 1'b0, 32'd0, 1'b1, 32'h100, 32'd0, 1'b0);
    rd_csr("mret_mstatus", 12'h300, 32'h88);

    // Interrupt beats exception; MEI beats MTI
    valid_in = 1'b1; exception_in = 1'b1; ecause_in = 4'd5; meip = 1'b1; mtip = 1'b1;
    pc_in = 32'h200;
    cyc("irq_prio", E_RDW | E_TRP | E_TA, 1'b0, 32'd0, 1'b1, 32'h80000100, 32'd0, 1'b0);
    rd_csr("prio_mcause", 12'h342, 32'h8000000B);
    rd_csr("prio_mstatus", 12'h300, 32'h80);
    rd_csr("prio_minstret", 12'hB02, 32'd8);

    // wfi sleep and wake without MIE
    valid_in = 1'b1; wfi_in = 1'b1; pc_in = 32'h300;
    cyc("wfi", E_TRP | E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc("sleep1", E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    csr_read_address = 12'hB02;
    cyc("sleep2", E_STL | E_CSR, 1'b0, 32'd0, 1'b0, 32'd0, 32'd9, 1'b1);
    meip = 1'b1;
    cyc("wake", E_STL | E_TRP, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc("awake", E_STL | E_TRP, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    valid_in = 1'b1; wfi_in = 1'b1; exception_in = 1'b1; ecause_in = 4'd3; pc_in = 32'h304;
    cyc("wfi_trap", E_TRP | E_TA | E_STL, 1'b0, 32'd0, 1'b1, 32'h80000100, 32'd0, 1'b0);
    csr_read_address = 12'h342;
    cyc("wfi_trap_run", E_STL | E_CSR, 1'b0, 32'd0, 1'b0, 32'd0, 32'd3, 1'b0);

    // 64-bit cycle counter carry, write wins over increment
    wr_csr("wr_mcycle", 12'hB00, 32'hFFFFFFFF);
    wr_csr("wr_mcycleh", 12'hB80, 32'd0);
    rd_csr("mcycleh0", 12'hB80, 32'd0);
    rd_csr("mcycleh1", 12'hB80, 32'd1);
    rd_csr("mcycle_lo", 12'hB00, 32'd1);
    rd_csr("cycleh", 12'hC80, 32'd1);

    // Unmapped and read-only addresses ignore writes
    wr_csr("wr_unmapped", 12'h7C0, 32'd1);
    rd_csr("unmapped", 12'h7C0, 32'd0);
    wr_csr("wr_mip", 12'h344, 32'hFFF);
    rd_csr("mip_ro", 12'h344, 32'd0);
    rd_csr("minstret13", 12'hB02, 32'd13);

    // Reset during SLEEP with a CSR write pending
    valid_in = 1'b1; wfi_in = 1'b1; pc_in = 32'h400;
    cyc("wfi2", E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc("sleep3", E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    reset = 1'b1;
    valid_in = 1'b1; csr_write_in = 1'b1; csr_address_in = 12'h340; alu_data_in = 32'hABCD;
    rd_address_in = 5'd5; csr_read_address = 12'h340;
    cyc("rst_sleep", E_RDW | E_TRP | E_CSR | E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    csr_read_address = 12'h340;
    cyc("rst_mscratch", E_CSR | E_STL, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    rd_csr("rst_mie", 12'h304, 32'd0);
    rd_csr("rst_mstatus", 12'h300, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage, directly downstream of the memory stage. Consumes one registered instruction record per cycle and retires it: selects register-file write data, commits CSR writes, maintains the machine-mode CSR set and counters, and takes traps, interrupts and `mret`. Runs the `wfi` sleep state machine and drives the trap redirect to fetch and the sleep stall to hazard.

## Interface
- No parameters.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pc_in, next_pc_in  in  32  PC and PC+4 of the retiring instruction.
- alu_data_in  in  32  ALU result; for CSR instructions, the new CSR value.
- csr_data_in  in  32  old CSR value, read in execute.
- load_data_in  in  32  extended load data.
- write_select_in  in  2  rd source: 00 alu, 01 csr, 10 load, 11 next_pc.
- rd_address_in  in  5  destination register; 0 means no write.
- csr_address_in  in  12; csr_write_in  in  1.
- mret_in, wfi_in  in  1.
- valid_in, exception_in  in  1; ecause_in  in  4.
- meip, mtip, msip  in  1  level interrupt sources.
- csr_read_address  in  12; csr_read_data  out  32  combinational read port for execute.
- rd_write  out  1; rd_address  out  5; rd_data  out  32  register-file write.
- trap  out  1; trap_address  out  32  fetch redirect.
- wfi_stall  out  1  to hazard.

## Operation
- `irq` = any of MEI, MSI, MTI with both the mip and mie bits set. Priority: MEI (11), then MSI (3), then MTI (7).
- A valid instruction is processed in this order:
  - Interrupt: when `irq` and mstatus.MIE are set. Wins over exceptions. The instruction does not retire; mepc <= pc_in; mcause <= {1, code}.
  - Exception: mepc <= pc_in; mcause <= {0, ecause_in}.
  - Otherwise `mret`: trap=1, trap_address=mepc, MIE <= MPIE, MPIE <= 1. The instruction retires.
  - Otherwise normal retire.
- On every interrupt or exception:
  - trap=1; trap_address = {mtvec[31:2], 2'b00} (direct mode only).
  - MPIE <= MIE; MIE <= 0.
  - No rd write, no CSR write.
- Retire:
  - rd_write = (rd_address_in != 0); rd_data per write_select_in.
  - If csr_write_in, the CSR at csr_address_in <= alu_data_in.
  - minstret += 1.
- CSR map:
  - mstatus 0x300: only MIE bit 3 and MPIE bit 7 exist; all other bits read 0.
  - mie 0x304: bits 3, 7, 11.
  - mtvec 0x305; mscratch 0x340; mepc 0x341, bits [1:0] forced 0; mcause 0x342.
  - mip 0x344: read-only, reflects the inputs.
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - cycle/instret 0xC00/0xC02 and their high halves 0xC80/0xC82: read-only mirrors.
  - Unmapped addresses read 0 and ignore writes.
- Counters: 64-bit. mcycle increments every cycle. A CSR write to either half wins over that cycle's increment.
- wfi FSM:
  - RUN: a retiring `wfi` moves to SLEEP.
  - SLEEP: wfi_stall=1. Returns to RUN the cycle after (mip & mie) != 0, independent of MIE. reset also returns to RUN.
  - A trap on the `wfi` itself keeps RUN.

## Timing
- rd_write, rd_data, trap, trap_address and csr_read_data are combinational from the current inputs and state. All state updates at the posedge.
- Latency: one instruction retires per cycle. CSR effects are visible on csr_read_data the next cycle.
- valid_in=0: all of rd_write, trap and any commit are 0; counters still run.
- Reset values:
  - All CSRs, both counters and MIE/MPIE are 0; FSM is RUN.
  - Outputs are 0, except rd_data/trap_address, which follow their inputs.
- A reset asserted mid-SLEEP or with a valid input cancels all commits that cycle.
- Interrupt wake and a valid input in the same cycle: the interrupt is taken on that instruction.
- Counter 0xFFFFFFFF increments carry into the high half; the 64-bit value wraps to 0.

## Structure
- Shared package holds:
  - CSR address constants.
  - write_select encodings.
  - Interrupt cause codes 3, 7 and 11, plus the mcause interrupt bit.
  - mstatus bit indices.
- One sub-module, `csr_file`: the register storage, read mux, counters and trap/mret updates. `writeback` keeps the priority logic, rd mux and wfi FSM.

## Test plan
- Retire `write_select_in`=10, rd=5, load=0xDEADBEEF -> rd_write=1, rd_data=0xDEADBEEF; minstret reads 1 next cycle.
- Write mtvec=0x80000103, then exception ecause=2 at pc 0x40 -> trap=1, trap_address=0x80000100; then mepc=0x40, mcause=2, rd_write=0.
- MIE=1, mie[7]=1, mtip=1, valid instruction at pc 0x100 -> trap, mcause=0x80000007, MIE=0, MPIE=1. Then `mret` -> trap_address=0x100, MIE=1.
- Retire `wfi` with MIE=0 -> wfi_stall high. Assert meip with mie[11]=1 -> stall drops next cycle and no trap is taken.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycleh=1.
- Assert reset during SLEEP with a CSR write pending -> wfi_stall=0, CSR unchanged (0).
